// File: rtl/snn_ann_pkg.sv
// ============================================================================
// snn_ann_pkg : shared constants, FSM encoding and spike-count helper for the
//               SNN->ANN frame sequencer.  Rev 1.0
// ============================================================================
`default_nettype none

package snn_ann_pkg;

    localparam int TIMESTEPS = 4;
    localparam int ANN_W     = 3;

    typedef enum logic [1:0] {
        COLLECT = 2'd0,
        ISSUE   = 2'd1,
        PRESENT = 2'd2
    } state_t;

    function automatic logic [ANN_W-1:0] spike_count(input logic [TIMESTEPS-1:0] spikes);
        logic [ANN_W-1:0] acc;
        acc = '0;
        for (int k = 0; k < TIMESTEPS; k++) begin
            acc = acc + {{(ANN_W-1){1'b0}}, spikes[k]};
        end
        return acc;
    endfunction

endpackage

`default_nettype wire

// File: rtl/snn_to_ann_single_neuron.sv
// ============================================================================
// snn_to_ann_single_neuron : counts the spikes of one neuron over four
//                            timesteps; result registered and held.  Rev 1.0
// ============================================================================
`default_nettype none

module snn_to_ann_single_neuron
    import snn_ann_pkg::*;
#(
    parameter int WIDTH = 3
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             valid_in,
    input  logic [3:0]       spikes_in,
    output logic             valid_out,
    output logic [WIDTH-1:0] ann_out
);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            valid_out <= 1'b0;
            ann_out   <= '0;
        end else begin
            valid_out <= valid_in;
            if (valid_in) begin
                ann_out <= WIDTH'(spike_count(spikes_in));
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/snn_to_ann_conv_ctrl.sv
// ============================================================================
// snn_to_ann_conv_ctrl : buffers one frame of spike vectors, then drains
//                        per-neuron spike counts through one shared converter.
//                        Rev 1.0
// ============================================================================
`default_nettype none

module snn_to_ann_conv_ctrl
    import snn_ann_pkg::*;
#(
    parameter int NUM_NEURONS = 16,
    parameter int TIMESTEPS   = snn_ann_pkg::TIMESTEPS,
    parameter int ANN_W       = snn_ann_pkg::ANN_W,
    parameter int IDX_W       = $clog2(NUM_NEURONS)
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   clr,
    input  logic                   spk_valid,
    output logic                   spk_ready,
    input  logic [NUM_NEURONS-1:0] spk_vec,
    output logic                   ann_valid,
    input  logic                   ann_ready,
    output logic [ANN_W-1:0]       ann_data,
    output logic [IDX_W-1:0]       ann_idx,
    output logic                   ann_last,
    output logic                   busy
);

    localparam int               TW     = $clog2(TIMESTEPS);
    localparam logic [TW-1:0]    T_LAST = TW'(TIMESTEPS - 1);
    localparam logic [IDX_W-1:0] N_LAST = IDX_W'(NUM_NEURONS - 1);

    if (TIMESTEPS != 4) begin : g_bad_timesteps
        $error("snn_to_ann_conv_ctrl: TIMESTEPS must be 4");
    end
    if (NUM_NEURONS < 2) begin : g_bad_neurons
        $error("snn_to_ann_conv_ctrl: NUM_NEURONS must be >= 2");
    end
    if (ANN_W != $clog2(TIMESTEPS) + 1) begin : g_bad_ann_w
        $error("snn_to_ann_conv_ctrl: ANN_W must equal clog2(TIMESTEPS)+1");
    end

    state_t                 state;
    state_t                 state_nxt;
    logic [TW-1:0]          t;
    logic [TW-1:0]          t_nxt;
    logic [IDX_W-1:0]       n;
    logic [IDX_W-1:0]       n_nxt;
    logic [NUM_NEURONS-1:0] spk_buf [TIMESTEPS];

    logic                   conv_valid;
    logic [3:0]             conv_spikes;
    logic [ANN_W-1:0]       conv_out;
    logic                   unused_conv_valid_out;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= COLLECT;
            t     <= '0;
            n     <= '0;
        end else begin
            state <= state_nxt;
            t     <= t_nxt;
            n     <= n_nxt;
        end
    end

    // Frame buffer has no reset; contents are only meaningful after a full frame.
    always_ff @(posedge clk) begin
        if (rst_n && !clr && spk_valid && (state == COLLECT)) begin
            spk_buf[t] <= spk_vec;
        end
    end

    always_comb begin
        state_nxt = state;
        t_nxt     = t;
        n_nxt     = n;
        if (clr) begin
            state_nxt = COLLECT;
            t_nxt     = '0;
            n_nxt     = '0;
        end else begin
            case (state)
                COLLECT: begin
                    if (spk_valid) begin
                        if (t == T_LAST) begin
                            t_nxt     = '0;
                            n_nxt     = '0;
                            state_nxt = ISSUE;
                        end else begin
                            t_nxt = t + 1'b1;
                        end
                    end
                end
                ISSUE: begin
                    state_nxt = PRESENT;
                end
                PRESENT: begin
                    if (ann_ready) begin
                        if (n == N_LAST) begin
                            state_nxt = COLLECT;
                        end else begin
                            n_nxt     = n + 1'b1;
                            state_nxt = ISSUE;
                        end
                    end
                end
                default: begin
                    state_nxt = COLLECT;
                end
            endcase
        end
    end

    // Transpose: converter input bit k is neuron n's spike at timestep k.
    always_comb begin
        conv_spikes = '0;
        for (int k = 0; k < TIMESTEPS; k++) begin
            conv_spikes[k] = spk_buf[k][n];
        end
    end

    assign conv_valid = (state == ISSUE);

    snn_to_ann_single_neuron #(
        .WIDTH (ANN_W)
    ) u_conv (
        .clk       (clk),
        .rst_n     (rst_n),
        .valid_in  (conv_valid),
        .spikes_in (conv_spikes),
        .valid_out (unused_conv_valid_out),
        .ann_out   (conv_out)
    );

    assign spk_ready = (state == COLLECT);
    assign ann_valid = (state == PRESENT);
    assign busy      = (state != COLLECT);
    assign ann_data  = conv_out;
    assign ann_idx   = n;
    assign ann_last  = ann_valid && (n == N_LAST);

endmodule

`default_nettype wire

// File: tb/tb_snn_to_ann_conv_ctrl.sv
// ============================================================================
// tb_snn_to_ann_conv_ctrl : scoreboard bench for the SNN->ANN frame sequencer.
//                           Rev 1.0
// ============================================================================
`default_nettype none

module tb_snn_to_ann_conv_ctrl;

    localparam int NN = 16;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          clr;
    logic          spk_valid;
    logic          spk_ready;
    logic [NN-1:0] spk_vec;
    logic          ann_valid;
    logic          ann_ready;
    logic [2:0]    ann_data;
    logic [3:0]    ann_idx;
    logic          ann_last;
    logic          busy;

    snn_to_ann_conv_ctrl #(.NUM_NEURONS(NN)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .clr       (clr),
        .spk_valid (spk_valid),
        .spk_ready (spk_ready),
        .spk_vec   (spk_vec),
        .ann_valid (ann_valid),
        .ann_ready (ann_ready),
        .ann_data  (ann_data),
        .ann_idx   (ann_idx),
        .ann_last  (ann_last),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        int idx;
        int data;
    } exp_t;

    exp_t sb[$];
    int   checks  = 0;
    int   errors  = 0;
    int   cyc     = 0;
    int   acc_cyc = 0;
    int   hs_cyc  = 0;
    bit   gap_chk = 1'b1;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, act, exp, $time);
        end
    endtask

    // Handshakes are observed on the falling edge, ahead of the rising edge that commits them.
    always @(negedge clk) begin
        if (rst_n && !clr && ann_valid && ann_ready) begin
            if (sb.size() == 0) begin
                check("sb_unexpected", 32'd1, 32'd0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check("ann_idx", 32'(ann_idx), 32'(e.idx));
                check("ann_data", 32'(ann_data), 32'(e.data));
                check("ann_last", 32'(ann_last), 32'(e.idx == NN - 1));
                check("spk_ready_drain", 32'(spk_ready), 32'd0);
                check("busy_drain", 32'(busy), 32'd1);
                if (gap_chk) begin
                    if (e.idx == 0) check("latency", 32'(cyc - acc_cyc), 32'd2);
                    else            check("spacing", 32'(cyc - hs_cyc), 32'd2);
                end
            end
            hs_cyc = cyc;
        end
    end

    // Called at posedge+#1; returns at posedge+#1 after the accepting edge.
    task automatic send_beat(input logic [NN-1:0] v, input int gap);
        bit got;
        got = 1'b0;
        repeat (gap) begin
            @(posedge clk); #1;
        end
        spk_valid = 1'b1;
        spk_vec   = v;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (spk_ready) begin
                acc_cyc = cyc;
                got     = 1'b1;
            end
            @(posedge clk); #1;
            if (got) break;
        end
        spk_valid = 1'b0;
        if (!got) check("beat_timeout", 32'd0, 32'd1);
    endtask

    task automatic send_frame(input logic [NN-1:0] b0, input logic [NN-1:0] b1,
                              input logic [NN-1:0] b2, input logic [NN-1:0] b3,
                              input int gap);
        for (int n = 0; n < NN; n++) begin
            exp_t e;
            e.idx  = n;
            e.data = int'(b0[n]) + int'(b1[n]) + int'(b2[n]) + int'(b3[n]);
            sb.push_back(e);
        end
        send_beat(b0, gap);
        send_beat(b1, gap);
        send_beat(b2, gap);
        send_beat(b3, gap);
    endtask

    task automatic wait_drain();
        for (int i = 0; i < 500; i++) begin
            if (sb.size() == 0) break;
            @(posedge clk); #1;
        end
        check("drain_left", 32'(sb.size()), 32'd0);
        @(negedge clk);
        check("idle_spk_ready", 32'(spk_ready), 32'd1);
        check("idle_busy", 32'(busy), 32'd0);
        check("idle_ann_valid", 32'(ann_valid), 32'd0);
        @(posedge clk); #1;
    endtask

    task automatic wait_issue(input int idx);
        bit found;
        found = 1'b0;
        for (int i = 0; i < 300; i++) begin
            if (busy && !ann_valid && (int'(ann_idx) == idx)) begin
                found = 1'b1;
                break;
            end
            @(posedge clk); #1;
        end
        if (!found) check("issue_timeout", 32'd0, 32'd1);
    endtask

    initial begin
        rst_n     = 1'b0;
        clr       = 1'b0;
        spk_valid = 1'b0;
        spk_vec   = '0;
        ann_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        check("rst_spk_ready", 32'(spk_ready), 32'd1);
        check("rst_ann_valid", 32'(ann_valid), 32'd0);
        check("rst_ann_idx", 32'(ann_idx), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        @(posedge clk); #1;

        // alternating all-ones / all-zeros beats
        send_frame(16'hFFFF, 16'h0000, 16'hFFFF, 16'h0000, 0);
        wait_drain();

        // staircase: neuron k fires in 4-k timesteps
        send_frame(16'h0001, 16'h0003, 16'h0007, 16'h000F, 0);
        wait_drain();

        // back-pressure at idx 3
        gap_chk = 1'b0;
        send_frame(16'hFFFF, 16'h0000, 16'hFFFF, 16'h0000, 0);
        wait_issue(3);
        ann_ready = 1'b0;
        @(posedge clk); #1;
        repeat (5) begin
            @(negedge clk);
            check("stall_valid", 32'(ann_valid), 32'd1);
            check("stall_idx", 32'(ann_idx), 32'd3);
            check("stall_data", 32'(ann_data), 32'd2);
            @(posedge clk); #1;
        end
        ann_ready = 1'b1;
        wait_drain();
        gap_chk = 1'b1;

        // idle gaps between beats
        send_frame(16'hFFFF, 16'h0000, 16'hFFFF, 16'h0000, 3);
        wait_drain();

        // clr after two beats; the beat presented with clr is dropped
        send_beat(16'hFFFF, 0);
        send_beat(16'hFFFF, 0);
        spk_valid = 1'b1;
        spk_vec   = 16'hFFFF;
        clr       = 1'b1;
        @(posedge clk); #1;
        clr       = 1'b0;
        spk_valid = 1'b0;
        @(negedge clk);
        check("clr_spk_ready", 32'(spk_ready), 32'd1);
        check("clr_busy", 32'(busy), 32'd0);
        @(posedge clk); #1;
        send_frame(16'h00FF, 16'h0F0F, 16'h3333, 16'h5555, 0);
        wait_drain();

        // clr while presenting idx 7
        send_frame(16'hA5A5, 16'h5A5A, 16'hFFFF, 16'h1234, 0);
        wait_issue(7);
        ann_ready = 1'b0;
        @(posedge clk); #1;
        @(negedge clk);
        check("pre_clr_valid", 32'(ann_valid), 32'd1);
        check("pre_clr_idx", 32'(ann_idx), 32'd7);
        @(posedge clk); #1;
        clr = 1'b1;
        @(posedge clk); #1;
        clr = 1'b0;
        @(negedge clk);
        check("clr_ann_valid", 32'(ann_valid), 32'd0);
        check("clr_drain_spk_ready", 32'(spk_ready), 32'd1);
        sb.delete();
        ann_ready = 1'b1;
        @(posedge clk); #1;

        // reset pulse while presenting idx 9
        send_frame(16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF, 0);
        wait_issue(9);
        ann_ready = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(negedge clk);
        check("mrst_ann_valid", 32'(ann_valid), 32'd0);
        check("mrst_ann_idx", 32'(ann_idx), 32'd0);
        check("mrst_spk_ready", 32'(spk_ready), 32'd1);
        sb.delete();
        ann_ready = 1'b1;
        @(posedge clk); #1;
        send_frame(16'h0001, 16'h0003, 16'h0007, 16'h000F, 0);
        wait_drain();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
